// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access unit: access size codes,
// FSM state encoding and the alignment rule used when DMEM_ALIGN_CHECK_EN
// is defined.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RD    = 3'd1,
      MERGE = 3'd2,
      WR    = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Halfwords need addr[0]=0; words (size 10 or 11) need addr[1:0]=0.
   function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
      if (size == SZ_HALF) return addrLo[0];
      if (size[1]) return (addrLo != 2'b00);
      return 1'b0;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian lane extraction/extension for loads and lane merge for
// sub-word stores. Byte k sits at bits [31-8k -: 8], halfword h at
// bits [31-16h -: 16]. Purely combinational.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addrLo,
   input  logic [1:0]  size,
   input  logic        isUnsigned,
   input  logic [31:0] storeData,
   output logic [31:0] loadData,
   output logic [31:0] mergedWord
);

   logic [7:0]  byteLane;
   logic [15:0] halfLane;

   // Select the addressed lanes out of the memory word.
   always_comb begin
      byteLane = word[31:24];
      case (addrLo)
         2'd0: byteLane = word[31:24];
         2'd1: byteLane = word[23:16];
         2'd2: byteLane = word[15:8];
         default: byteLane = word[7:0];
      endcase
      halfLane = addrLo[1] ? word[15:0] : word[31:16];
   end

   // Extend the load lane and overlay the store lane onto the read word.
   always_comb begin
      loadData   = word;
      mergedWord = word;
      case (size)
         SZ_BYTE: begin
            loadData = {{24{~isUnsigned & byteLane[7]}}, byteLane};
            case (addrLo)
               2'd0: mergedWord[31:24] = storeData[7:0];
               2'd1: mergedWord[23:16] = storeData[7:0];
               2'd2: mergedWord[15:8]  = storeData[7:0];
               default: mergedWord[7:0] = storeData[7:0];
            endcase
         end
         SZ_HALF: begin
            loadData = {{16{~isUnsigned & halfLane[15]}}, halfLane};
            if (addrLo[1]) mergedWord[15:0]  = storeData[15:0];
            else           mergedWord[31:16] = storeData[15:0];
         end
         default: begin
            loadData   = word;
            mergedWord = storeData;
         end
      endcase
   end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage load/store unit driving a word-wide, big-endian data memory
// with one-edge registered read latency. Sub-word stores use
// read-modify-write. Optional misalignment trapping is enabled by
// defining DMEM_ALIGN_CHECK_EN.
//
// Handshake: a request is taken at the rising edge where req_valid and
// req_ready are both high; req_ready is high only in IDLE, so the pipeline
// holds the request until then. resp_valid is a one-cycle pulse in DONE,
// with resp_err qualified by it.
module dmem_access_unit
   import dmem_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic [ADDR_W-1:0] address,
   output logic [31:0]       writeData,
   output logic              memWrite,
   output logic              memRead,
   input  logic [31:0]       readData,
   output state_t            dbgState
);

   state_t            state, nextState;
   logic              opWe, opUns, misReq;
   logic [1:0]        opSize;
   logic [ADDR_W-1:0] opAddr;
   logic [31:0]       opWdata, wrBuf, respRdata, loadData, mergedWord;

`ifdef DMEM_ALIGN_CHECK_EN
   logic misFlag;
   assign misReq = isMisaligned(req_size, req_addr[1:0]);

   // Remember whether the accepted request was trapped as misaligned.
   always_ff @(posedge clk) begin
      if (reset)                            misFlag <= 1'b0;
      else if (state == IDLE && req_valid)  misFlag <= misReq;
   end
   assign resp_err = (state == DONE) && misFlag;
`else
   assign misReq   = 1'b0;
   assign resp_err = 1'b0;
`endif

   dmem_lane_align u_align (
      .word       (readData),
      .addrLo     (opAddr[1:0]),
      .size       (opSize),
      .isUnsigned (opUns),
      .storeData  (opWdata),
      .loadData   (loadData),
      .mergedWord (mergedWord)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   // Next-state logic and memory/pipeline strobes decoded from state.
   always_comb begin
      nextState  = state;
      req_ready  = 1'b0;
      memRead    = 1'b0;
      memWrite   = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (misReq)                     nextState = DONE;
               else if (req_we && req_size[1]) nextState = WR;
               else                            nextState = RD;
            end
         end
         RD: begin
            memRead   = 1'b1;
            nextState = MERGE;
         end
         MERGE:   nextState = opWe ? WR : DONE;
         WR: begin
            memWrite  = 1'b1;
            nextState = DONE;
         end
         DONE: begin
            resp_valid = 1'b1;
            nextState  = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Request latch, write buffer and load result register.
   always_ff @(posedge clk) begin
      if (reset) begin
         opWe      <= 1'b0;
         opUns     <= 1'b0;
         opSize    <= SZ_BYTE;
         opAddr    <= '0;
         opWdata   <= '0;
         wrBuf     <= '0;
         respRdata <= '0;
      end else begin
         case (state)
            IDLE: if (req_valid) begin
               opWe    <= req_we;
               opUns   <= req_unsigned;
               opSize  <= req_size;
               opAddr  <= req_addr;
               opWdata <= req_wdata;
               if (req_we && req_size[1] && !misReq) wrBuf <= req_wdata;
            end
            MERGE: begin
               if (opWe) wrBuf     <= mergedWord;
               else      respRdata <= loadData;
            end
            default: ;
         endcase
      end
   end

   assign address    = {opAddr[ADDR_W-1:2], 2'b00};
   assign writeData  = wrBuf;
   assign resp_rdata = respRdata;
   assign dbgState   = state;

endmodule
